param_slider_bank: RTL and testbench
====================================

PARAM_SLIDER_BANK -- requirements
Module: param_slider_bank

Interface
REQ-001 Parameter NCH, default 6: number of parameter channels (2..16).
REQ-002 Parameter W, default 6: width of each channel value (1..8).
REQ-003 Parameter DEFAULTS, default {6'd63,6'd63,6'd0,6'd63,6'd63,6'd4}: packed NCH*W reset values, channel 0 in the LSBs.
REQ-004 Parameter WRAP, default 0: 0 = saturate at 0 and 2^W-1; 1 = modular wrap.
REQ-005 Parameter REPEAT_DELAY, default 25000000: hold cycles from first step to first auto-repeat step (>=2).
REQ-006 Parameter REPEAT_RATE, default 5000000: cycles between subsequent auto-repeat steps (>=1).
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 sel  input  SW=max(1,clog2(NCH))  channel selected for inc/dec/load; values >= NCH ignore all commands.
REQ-010 inc  input  1  level, button held = increment request.
REQ-011 dec  input  1  level, button held = decrement request.
REQ-012 load  input  1  one-cycle absolute write of load_val into selected channel.
REQ-013 load_val  input  W  value written by load.
REQ-014 values  output  NCH*W  all channel values, registered, channel i at bits [i*W +: W].
REQ-015 sel_value  output  W  registered copy of channel sel (0 if sel >= NCH), valid the cycle after sel/value changes.
REQ-016 changed  output  1  one-cycle pulse, the cycle after any channel value actually changed.

Function
REQ-017 FSM states IDLE, DELAY, REPEAT, LOCKED; cycle counter cnt wide enough for max(REPEAT_DELAY, REPEAT_RATE); latched direction dir and channel lsel.
REQ-018 IDLE: exactly one of inc/dec sampled high -> one step on that edge, latch dir and lsel=sel, cnt<=0, go DELAY; both high -> LOCKED, no step.
REQ-019 DELAY: cnt increments each cycle; on the edge where cnt==REPEAT_DELAY-1 -> step, cnt<=0, go REPEAT.
REQ-020 REPEAT: cnt increments; on the edge where cnt==REPEAT_RATE-1 -> step, cnt<=0.
REQ-021 Net effect: press sampled at edge k steps at k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, then every REPEAT_RATE.
REQ-022 DELAY/REPEAT: inc=dec=0 -> IDLE; sel != lsel, both high, or active button differs from dir -> LOCKED, no step.
REQ-023 LOCKED: no steps; -> IDLE when inc=dec=0.
REQ-024 Step: value +1 (dir=inc) or -1 (dir=dec) at W bits; WRAP=0 holds at 2^W-1 / 0, no change and no changed pulse; WRAP=1 wraps 2^W-1<->0.
REQ-025 load=1 with sel<NCH: channel sel <= load_val on that edge; overrides any step that edge; FSM -> LOCKED if inc|dec else IDLE.
REQ-026 Only one channel is modified per cycle; unselected channels hold.
REQ-027 changed=1 the cycle after a step or load where the new value differs from the old; load of an identical value gives no pulse.
REQ-028 sel >= NCH: inc/dec/load ignored, FSM to LOCKED if inc|dec else IDLE.

Reset
REQ-029 reset=0 at a rising edge: every channel <= its DEFAULTS field, FSM IDLE, cnt 0, changed 0, sel_value updated from DEFAULTS the following cycle.
REQ-030 Reset overrides load and held buttons; a button still held when reset releases is not a new press (FSM enters LOCKED on first post-reset edge until released).

Verification (NCH=6, W=6, REPEAT_DELAY=4, REPEAT_RATE=2, WRAP=0)
REQ-031 Reset -> values = {63,63,0,63,63,4}, changed 0, sel=0 gives sel_value 4.
REQ-032 sel=0, inc high edges 10..19 -> ch0 steps at edges 10,14,16,18: 4->8, four changed pulses, other channels unchanged.
REQ-033 sel=1 (63), inc one cycle -> ch1 stays 63, no changed; with WRAP=1 -> ch1 becomes 0, changed pulses.
REQ-034 sel=3 (0), dec held, then inc added at edge +2 -> ch3 stays 0 (saturated), FSM LOCKED, no steps until both released, then fresh inc press -> 1.
REQ-035 sel=2, inc held, load=1 load_val=17 at edge +1 -> ch2=17, no further steps until inc released; sel switched mid-hold also freezes stepping.
REQ-036 inc held through reset pulse -> defaults restored, no step after reset until inc released and re-pressed.

Source files
------------

// File: rtl/param_slider_bank.sv
// Bank of NCH W-bit parameter registers driven by inc/dec buttons with
// hold-to-auto-repeat, plus absolute loads of the selected channel.
module param_slider_bank #(
  parameter int NCH = 6,
  parameter int W = 6,
  parameter logic [NCH*W-1:0] DEFAULTS = {6'd63, 6'd63, 6'd0, 6'd63, 6'd63, 6'd4},
  parameter int WRAP = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE = 5000000,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW-1:0]     sel,
  input  logic              inc,
  input  logic              dec,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  output logic [NCH*W-1:0]  values,
  output logic [W-1:0]      sel_value,
  output logic              changed
);

  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [W-1:0]  VMAX = '1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      dir_q, dir_d;      // 1 = increment
  logic [SW-1:0]             lsel_q, lsel_d;
  logic                      post_rst_q;
  logic [NCH-1:0][W-1:0]     vals_q, vals_d;
  logic [W-1:0]              sel_value_q;
  logic                      changed_q, changed_d;

  logic                      sel_ok, any_btn, both_btn;
  logic                      do_step, step_up, wr_en;
  logic [SW-1:0]             wr_idx;
  logic [W-1:0]              wr_val, old_val;

  function automatic logic [W-1:0] chan(input logic [NCH-1:0][W-1:0] v,
                                        input logic [SW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      if (32'(idx) == i) r = v[i];
    return r;
  endfunction

  assign sel_ok   = 32'(sel) < NCH;
  assign any_btn  = inc | dec;
  assign both_btn = inc & dec;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    lsel_d  = lsel_q;
    do_step = 1'b0;
    step_up = dir_q;
    wr_en   = 1'b0;
    wr_idx  = lsel_q;
    wr_val  = '0;

    if (!sel_ok) begin
      state_d = any_btn ? LOCKED : IDLE;
    end else if (load) begin
      wr_en   = 1'b1;
      wr_idx  = sel;
      wr_val  = load_val;
      state_d = any_btn ? LOCKED : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A button already down when reset released is not a new press.
          if (any_btn) begin
            if (post_rst_q || both_btn) begin
              state_d = LOCKED;
            end else begin
              do_step = 1'b1;
              step_up = inc;
              wr_idx  = sel;
              dir_d   = inc;
              lsel_d  = sel;
              cnt_d   = '0;
              state_d = DELAY;
            end
          end
        end
        DELAY, REPEAT: begin
          if (!any_btn) begin
            state_d = IDLE;
          end else if (sel != lsel_q || both_btn || inc != dir_q) begin
            state_d = LOCKED;
          end else if (cnt_q == ((state_q == DELAY) ? DLY_LAST : RATE_LAST)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!any_btn) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    old_val = chan(vals_q, wr_idx);
    if (do_step) begin
      wr_en = 1'b1;
      if (step_up)
        wr_val = (old_val == VMAX && WRAP == 0) ? old_val : old_val + 1'b1;
      else
        wr_val = (old_val == '0 && WRAP == 0) ? old_val : old_val - 1'b1;
    end

    vals_d = vals_q;
    for (int i = 0; i < NCH; i++)
      if (wr_en && 32'(wr_idx) == i) vals_d[i] = wr_val;

    changed_d = wr_en && (wr_val != old_val);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      lsel_q     <= '0;
      post_rst_q <= 1'b1;
      vals_q     <= DEFAULTS;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      lsel_q     <= lsel_d;
      post_rst_q <= 1'b0;
      vals_q     <= vals_d;
      changed_q  <= changed_d;
    end
  end

  // NOTE: sel_value is a pure registered view of vals_q and is deliberately
  // left out of reset; it picks up the defaults one cycle after the reset edge.
  always_ff @(posedge clk) begin
    sel_value_q <= sel_ok ? chan(vals_q, sel) : '0;
  end

  assign values    = vals_q;
  assign sel_value = sel_value_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_param_slider_bank.sv
// Directed bench for param_slider_bank: a saturating and a wrapping instance
// share stimulus; expected values are hand-computed per step.
module tb_param_slider_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel;
  logic        inc, dec, load;
  logic [5:0]  load_val;
  logic [35:0] values, values_w;
  logic [5:0]  sel_value, sel_value_w;
  logic        changed, changed_w;

  int vectors = 0;
  int miscompares = 0;

  int exp_ch0 [10] = '{5, 5, 5, 5, 6, 6, 7, 7, 8, 8};
  int exp_chg [10] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0};

  param_slider_bank #(.NCH(6), .W(6), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .values(values), .sel_value(sel_value), .changed(changed));

  param_slider_bank #(.NCH(6), .W(6), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_w (
    .clk(clk), .reset(reset), .sel(sel), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .values(values_w), .sel_value(sel_value_w), .changed(changed_w));

  always #5 clk = ~clk;

  function automatic logic [35:0] pk(input int c5, c4, c3, c2, c1, c0);
    return {6'(c5), 6'(c4), 6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; sel = 3'd0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_val = 6'd0;
    tick(); tick();
    check("rst_values", values, pk(63, 63, 0, 63, 63, 4));
    check("rst_values_w", values_w, pk(63, 63, 0, 63, 63, 4));
    check("rst_changed", changed, 0);
    reset = 1'b1;
    tick();
    check("rst_sel_value", sel_value, 4);

    // Held inc on ch0: steps at press, +4, +6, +8
    inc = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      check($sformatf("rep_val%0d", n), values, pk(63, 63, 0, 63, 63, exp_ch0[n]));
      check($sformatf("rep_chg%0d", n), changed, exp_chg[n]);
    end
    inc = 1'b0;
    tick();
    check("rep_release", values, pk(63, 63, 0, 63, 63, 8));
    check("rep_sel_value", sel_value, 8);

    // Saturate vs wrap at the top of ch1
    sel = 3'd1; inc = 1'b1;
    tick();
    check("sat_val", values, pk(63, 63, 0, 63, 63, 8));
    check("sat_chg", changed, 0);
    check("wrap_val", values_w[11:6], 0);
    check("wrap_chg", changed_w, 1);
    inc = 1'b0;
    tick();

    // Dec at 0 on ch3, then inc added: locked until both released
    sel = 3'd3; dec = 1'b1;
    tick();
    check("dec0_val", values, pk(63, 63, 0, 63, 63, 8));
    check("dec0_chg", changed, 0);
    tick();
    inc = 1'b1;
    tick(); tick();
    dec = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check("lock_hold", values, pk(63, 63, 0, 63, 63, 8));
    inc = 1'b0;
    tick();
    inc = 1'b1;
    tick();
    check("fresh_inc", values, pk(63, 63, 1, 63, 63, 8));
    check("fresh_chg", changed, 1);
    inc = 1'b0;
    tick();

    // Load during a hold on ch2 freezes stepping
    sel = 3'd2; inc = 1'b1;
    tick();
    check("ch2_sat", changed, 0);
    load = 1'b1; load_val = 6'd17;
    tick();
    check("load_val", values, pk(63, 63, 1, 17, 63, 8));
    check("load_chg", changed, 1);
    load = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("load_lock", values, pk(63, 63, 1, 17, 63, 8));
    check("load_lock_chg", changed, 0);
    inc = 1'b0;
    tick();
    check("ch2_sel_value", sel_value, 17);
    inc = 1'b1;
    tick();
    check("ch2_step", values, pk(63, 63, 1, 18, 63, 8));
    sel = 3'd0;
    for (int n = 0; n < 7; n++) tick();
    check("selsw_lock", values, pk(63, 63, 1, 18, 63, 8));
    inc = 1'b0;
    tick();

    // Identical load gives no pulse
    sel = 3'd4; load = 1'b1; load_val = 6'd63;
    tick();
    check("same_load_chg", changed, 0);
    check("same_load_val", values, pk(63, 63, 1, 18, 63, 8));
    load = 1'b0;

    // Out-of-range select ignores everything
    sel = 3'd6; inc = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    sel = 3'd7; load = 1'b1; load_val = 6'd5;
    tick();
    check("oor_val", values, pk(63, 63, 1, 18, 63, 8));
    check("oor_chg", changed, 0);
    tick();
    check("oor_sel_value", sel_value, 0);
    load = 1'b0; inc = 1'b0;
    tick();

    // Inc held through reset is not a new press
    sel = 3'd0; inc = 1'b1;
    tick();
    check("pre_rst_step", values, pk(63, 63, 1, 18, 63, 9));
    reset = 1'b0;
    tick();
    check("rst2_val", values, pk(63, 63, 0, 63, 63, 4));
    check("rst2_chg", changed, 0);
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      check($sformatf("post_rst%0d", n), values, pk(63, 63, 0, 63, 63, 4));
    end
    inc = 1'b0;
    tick();
    inc = 1'b1;
    tick();
    check("repress_val", values, pk(63, 63, 0, 63, 63, 5));
    check("repress_chg", changed, 1);
    inc = 1'b0;
    tick();
    check("repress_sel_value", sel_value, 5);
    check("repress_chg_end", changed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
